// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: received-word write port from the deframer into the RX FIFO.
// master drives one {err,data} word per frame with a single-cycle strobe; slave is the FIFO side.
interface uart_rx_deframer_if;
   logic [8:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   modport master (output rx_data, rx_valid, frame_err);
   modport slave  (input rx_data, rx_valid, frame_err);
endinterface

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive deframer delivering {err,data} words to the RX FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_deframer #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32
) (
   input  logic               i_sys_clk,
   input  logic               i_sys_rstn,
   input  logic [CNT_W-1:0]   i_fre_cnt,
   input  logic [3:0]         i_rx_data_bit,
   input  logic [1:0]         i_parity_mode,
   input  logic [1:0]         i_stop_bit,
   input  logic               i_uart_rx,
   output logic               o_busy,
   uart_rx_deframer_if.master rx
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] BRK    = 3'd5;

   logic [SYNC_STAGES-1:0] sync;
   logic                   line;
   logic                   line_q;
   logic [2:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       fre_l;
   logic [CNT_W-1:0]       fre_eff;
   logic [2:0]             nb_m1;
   logic                   par_en;
   logic                   par_odd;
   logic                   two_stop;
   logic [7:0]             sh;
   logic [2:0]             bcnt;
   logic                   scnt;
   logic                   perr;
   logic                   ferr;
   logic                   ferr_n;
   logic                   par_x;
   logic                   start;
   logic                   tick;
   logic                   smp;
   logic                   bit_v;

   always_ff @(posedge i_sys_clk or negedge i_sys_rstn)
      if (!i_sys_rstn) begin
         sync   <= '1;
         line_q <= 1'b1;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], i_uart_rx};
         line_q <= line;
      end

   assign line    = sync[SYNC_STAGES-1];
   assign start   = state == IDLE && line_q && !line;
   assign fre_eff = i_fre_cnt < CNT_W'(4) ? CNT_W'(4) : i_fre_cnt;
   assign tick    = state != IDLE && state != BRK && cnt == '0;
   assign ferr_n  = ferr | ~bit_v;
   assign par_x   = ^sh ^ bit_v;
   assign o_busy  = state != IDLE;

`ifdef UART_RX_MAJORITY_EN
   // hist[0]/hist[1] hold the line at count 0 and count 1; the vote lands one cycle after count 0
   logic [1:0] hist;
   logic       pend;
   always_ff @(posedge i_sys_clk or negedge i_sys_rstn)
      if (!i_sys_rstn) begin
         hist <= '1;
         pend <= 1'b0;
      end else begin
         hist <= {hist[0], line};
         pend <= tick;
      end
   assign smp   = pend;
   assign bit_v = (line & hist[0]) | (line & hist[1]) | (hist[0] & hist[1]);
`else
   assign smp   = tick;
   assign bit_v = line;
`endif

   always_ff @(posedge i_sys_clk or negedge i_sys_rstn)
      if (!i_sys_rstn) begin
         state        <= IDLE;
         cnt          <= '0;
         fre_l        <= '0;
         nb_m1        <= '0;
         par_en       <= 1'b0;
         par_odd      <= 1'b0;
         two_stop     <= 1'b0;
         sh           <= '0;
         bcnt         <= '0;
         scnt         <= 1'b0;
         perr         <= 1'b0;
         ferr         <= 1'b0;
         rx.rx_data   <= '0;
         rx.rx_valid  <= 1'b0;
         rx.frame_err <= 1'b0;
      end else begin
         rx.rx_valid  <= 1'b0;
         rx.frame_err <= 1'b0;
         if (state == IDLE)
            cnt <= start ? (fre_eff >> 1) - CNT_W'(1) : '0;
         else
            cnt <= cnt == '0 ? fre_l - CNT_W'(1) : cnt - CNT_W'(1);
         if (start) begin
            state    <= START;
            fre_l    <= fre_eff;
            nb_m1    <= (i_rx_data_bit >= 4'd5 && i_rx_data_bit <= 4'd8) ? 3'(i_rx_data_bit - 4'd1) : 3'd7;
            par_en   <= ^i_parity_mode;
            par_odd  <= i_parity_mode == 2'b01;
            two_stop <= i_stop_bit == 2'b10;
            sh       <= '0;
            bcnt     <= '0;
            scnt     <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
         end
         if (smp)
            case (state)
               START: state <= bit_v ? IDLE : DATA;
               DATA: begin
                  sh[bcnt] <= bit_v;
                  bcnt     <= bcnt + 3'd1;
                  if (bcnt == nb_m1) state <= par_en ? PARITY : STOP;
               end
               PARITY: begin
                  perr  <= par_odd ? ~par_x : par_x;
                  state <= STOP;
               end
               STOP:
                  if (two_stop && !scnt) begin
                     scnt <= 1'b1;
                     ferr <= ferr_n;
                  end else begin
                     rx.rx_valid  <= 1'b1;
                     rx.frame_err <= ferr_n;
                     rx.rx_data   <= {perr | ferr_n, sh};
                     state        <= (!bit_v && ferr_n) ? BRK : IDLE;
                  end
               default: ;
            endcase
         if (state == BRK && line) state <= IDLE;
      end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed and randomized frames checked against a word-level UART model.
// Expected words come from the frame contents and line rules, not from the deframer's state machine.
module tb_uart_rx_deframer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] fre_cnt = 32'd16;
   logic [3:0]  data_bit = 4'd8;
   logic [1:0]  parity_mode = 2'b00;
   logic [1:0]  stop_bit = 2'b01;
   logic        uart_rx = 1'b1;
   logic        busy;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          stray = 0;
   int          t_start = 0;
   logic [8:0]  got_q[$];
   logic        fe_q[$];
   int          t_q[$];
   logic [8:0]  exp_q[$];
   logic        exp_fe[$];
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   uart_rx_deframer_if rx_if ();

   uart_rx_deframer dut (
      .i_sys_clk(clk), .i_sys_rstn(rst_n), .i_fre_cnt(fre_cnt), .i_rx_data_bit(data_bit),
      .i_parity_mode(parity_mode), .i_stop_bit(stop_bit), .i_uart_rx(uart_rx),
      .o_busy(busy), .rx(rx_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (rx_if.rx_valid) begin
         got_q.push_back(rx_if.rx_data);
         fe_q.push_back(rx_if.frame_err);
         t_q.push_back(cyc);
      end else if (rx_if.frame_err) stray++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drain(input string tag);
      check({tag, " count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         check({tag, " word"}, got_q.pop_front(), exp_q.pop_front());
         check({tag, " ferr"}, fe_q.pop_front(), exp_fe.pop_front());
      end
      got_q.delete(); fe_q.delete(); t_q.delete(); exp_q.delete(); exp_fe.delete();
   endtask

   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame from the current config; rst_bit aborts the frame with a reset at that data bit
   task automatic send_frame(input logic [7:0] d, input int glitch_bit, input int rst_bit,
                             input bit flip_par, input bit stop_v, input bit scramble);
      logic [31:0] sf;
      logic [3:0]  sd;
      logic [1:0]  sp, ss;
      logic [7:0]  dm;
      logic        bits[$];
      int          nb, ns, f, half;
      bit          pen;
      sf = fre_cnt; sd = data_bit; sp = parity_mode; ss = stop_bit;
      f = int'(sf); half = f / 2;
      nb = (sd >= 4'd5 && sd <= 4'd8) ? int'(sd) : 8;
      ns = (ss == 2'b10) ? 2 : 1;
      pen = sp == 2'b01 || sp == 2'b10;
      dm = d & 8'((1 << nb) - 1);
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
      if (pen) bits.push_back((sp == 2'b01 ? ~^dm : ^dm) ^ flip_par);
      for (int i = 0; i < ns; i++) bits.push_back(stop_v);
      t_start = cyc;
      for (int i = 0; i < bits.size(); i++) begin
         if (rst_bit >= 0 && i == rst_bit + 1) begin
            uart_rx = 1'b1;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check("rst data", rx_if.rx_data, 9'h000);
            rst_n = 1'b1;
            fre_cnt = sf; data_bit = sd; parity_mode = sp; stop_bit = ss;
            return;
         end
         uart_rx = bits[i];
         if (i == 0 && scramble) begin
            repeat (4) @(negedge clk);
            fre_cnt = $urandom_range(4, 40); data_bit = 4'($urandom_range(0, 15));
            parity_mode = 2'($urandom_range(0, 3)); stop_bit = 2'($urandom_range(0, 3));
            repeat (f - 4) @(negedge clk);
         end else if (i == glitch_bit + 1 && glitch_bit >= 0) begin
            repeat (half) @(negedge clk);
            uart_rx = ~bits[i];
            @(negedge clk);
            uart_rx = bits[i];
            repeat (f - half - 1) @(negedge clk);
         end else repeat (f) @(negedge clk);
      end
      fre_cnt = sf; data_bit = sd; parity_mode = sp; stop_bit = ss;
      exp_q.push_back({(pen & flip_par) | ~stop_v, dm});
      exp_fe.push_back(~stop_v);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst valid", rx_if.rx_valid, 1'b0);
      check("rst data0", rx_if.rx_data, 9'h000);
      check("rst ferr", rx_if.frame_err, 1'b0);
      check("rst busy", busy, 1'b0);
      rst_n = 1'b1;
      idle(4);

      send_frame(8'hA5, -1, -1, 0, 1, 0);
      idle(8);
      check("8n1 latency", t_q.size() > 0 ? t_q[0] - t_start : -1, 2 + 8 + 9 * 16 + 1 + MAJ);
      drain("8n1 a5");

      data_bit = 4'd7; parity_mode = 2'b10;
      send_frame(8'h41, -1, -1, 1, 1, 0);
      idle(20);
      check("7e1 word", exp_q.size() > 0 ? exp_q[0] : 9'h0, 9'h141);
      drain("7e1 bad par");
      data_bit = 4'd8; parity_mode = 2'b00;

      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      check("short busy", busy, 1'b1);
      idle(30);
      check("short idle", busy, 1'b0);
      drain("short low");

      send_frame(8'h00, -1, -1, 0, 0, 0);
      uart_rx = 1'b0;
      repeat (200) @(negedge clk);
      check("break busy", busy, 1'b1);
      idle(6);
      check("break idle", busy, 1'b0);
      drain("break");
      send_frame(8'h5A, -1, -1, 0, 1, 0);
      idle(20);
      drain("after break");

      stop_bit = 2'b10;
      send_frame(8'h12, -1, -1, 0, 1, 0);
      send_frame(8'h34, -1, -1, 0, 1, 0);
      idle(20);
      check("b2b gap", t_q.size() > 1 ? t_q[1] - t_q[0] : -1, 11 * 16);
      drain("8n2 b2b");
      stop_bit = 2'b01;

      send_frame(8'h33, -1, 3, 0, 1, 0);
      idle(40);
      check("abort busy", busy, 1'b0);
      drain("abort");
      send_frame(8'h7E, -1, -1, 0, 1, 0);
      idle(20);
      drain("after abort");

      send_frame(8'hA5, 2, -1, 0, 1, 0);
      idle(20);
      check("glitch word", got_q.size() > 0 ? got_q[0] : 9'h1FF, MAJ ? 9'h0A5 : 9'h0A1);
      got_q.delete(); fe_q.delete(); t_q.delete(); exp_q.delete(); exp_fe.delete();

      for (int n = 0; n < 16; n++) begin
         fre_cnt = $urandom_range(10, 24);
         data_bit = 4'($urandom_range(3, 9));
         parity_mode = 2'($urandom_range(0, 3));
         stop_bit = 2'($urandom_range(0, 3));
         send_frame(8'($urandom), -1, -1, 1'($urandom_range(0, 1)), 1, 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
      end
      idle(80);
      drain("random");

      check("stray ferr", stray, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
